lzc_norm_pipe: RTL and testbench

- Parametrised, pipelined leading/trailing-one detector with normalising shifter for the EX stage. Used for FP normalisation, integer CLZ/CTZ and priority selection.
- Generalises the fixed 16-bit combinational LZC:
  - any power-of-two width
  - per-transaction leading/trailing mode
  - zero count and normalised data outputs
  - 2-stage valid/ready pipeline with backpressure and sideband tag

---
 rtl/lzc_norm_pipe.sv | 85 ++++++++
 tb/tb_lzc_norm_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading/trailing-one detector with normalising shifter
module lzc_norm_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_pos,
  output logic [CW:0]      out_cnt,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);
  logic             s1_valid, s1_mode, s1_zero, s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_data, tv;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0]    s1_pos, ti [WIDTH], hi, pos;
  logic [CW:0]      s1_cnt, cnt;
  logic             zero;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  // Trailing mode bit-reverses the operand so one MSB-first tree serves both;
  // the tree is folded in place, node n combining children 2n (low) and 2n+1 (high).
  always_comb begin
    for (int i = 0; i < WIDTH; i++) tv[i] = in_mode ? in_data[WIDTH-1-i] : in_data[i];
    for (int i = 0; i < WIDTH; i++) ti[i] = '0;
    for (int l = 0; l < CW; l++)
      for (int n = 0; n < (WIDTH >> (l + 1)); n++) begin
        ti[n] = tv[2*n+1] ? (ti[2*n+1] | (CW'(1) << l)) : ti[2*n];
        tv[n] = tv[2*n+1] | tv[2*n];
      end
    hi   = ti[0];
    zero = !tv[0];
    cnt  = zero ? (CW+1)'(WIDTH) : {1'b0, ~hi};
    pos  = zero ? '0 : (in_mode ? ~hi : hi);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_data   <= '0;
      s1_tag    <= '0;
      s1_pos    <= '0;
      s1_cnt    <= '0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_cnt   <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
      out_tag   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_mode <= in_mode;
          s1_tag  <= in_tag;
          s1_pos  <= pos;
          s1_cnt  <= cnt;
          s1_zero <= zero;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_pos  <= s1_pos;
          out_cnt  <= s1_cnt;
          out_zero <= s1_zero;
          out_tag  <= s1_tag;
          out_norm <= s1_zero ? '0 : (s1_mode ? s1_data >> s1_cnt : s1_data << s1_cnt);
        end
      end
    end
  end
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: directed and randomized checks of lzc_norm_pipe at widths 8/16/32/64
module tb_lzc_norm_pipe;
  typedef struct packed {
    logic [6:0]  pos;
    logic [7:0]  cnt;
    logic        zero;
    logic [63:0] norm;
  } res_t;
  typedef struct {
    logic [63:0] d;
    logic        m;
    logic [3:0]  t;
  } txn_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [63:0] din = '0;
  logic [3:0]  in_tag = '0;
  logic rdy8, ov8, z8, rdy16, ov16, z16, rdy32, ov32, z32, rdy64, ov64, z64;
  logic [2:0] pos8;  logic [3:0] cnt8;  logic [7:0]  norm8;  logic [3:0] tag8;
  logic [3:0] pos16; logic [4:0] cnt16; logic [15:0] norm16; logic [3:0] tag16;
  logic [4:0] pos32; logic [5:0] cnt32; logic [31:0] norm32; logic [3:0] tag32;
  logic [5:0] pos64; logic [6:0] cnt64; logic [63:0] norm64; logic [3:0] tag64;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  lzc_norm_pipe #(.WIDTH(8), .TAG_W(4)) d8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(din[7:0]), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov8), .out_ready(out_ready),
    .out_pos(pos8), .out_cnt(cnt8), .out_zero(z8), .out_norm(norm8), .out_tag(tag8));
  lzc_norm_pipe #(.WIDTH(16), .TAG_W(4)) d16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .in_data(din[15:0]), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov16), .out_ready(out_ready),
    .out_pos(pos16), .out_cnt(cnt16), .out_zero(z16), .out_norm(norm16), .out_tag(tag16));
  lzc_norm_pipe #(.WIDTH(32), .TAG_W(4)) d32 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_data(din[31:0]), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_pos(pos32), .out_cnt(cnt32), .out_zero(z32), .out_norm(norm32), .out_tag(tag32));
  lzc_norm_pipe #(.WIDTH(64), .TAG_W(4)) d64 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_data(din), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .out_pos(pos64), .out_cnt(cnt64), .out_zero(z64), .out_norm(norm64), .out_tag(tag64));
  // Reference: scan bit by bit in the selected direction, counting zeros.
  function automatic res_t model(int w, logic [63:0] d, logic m);
    res_t r;
    logic [63:0] mask;
    logic found;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = d & mask;
    r = '0;
    r.cnt = 8'(w);
    r.zero = 1'b1;
    found = 1'b0;
    for (int k = 0; k < w; k++) begin
      int i;
      i = m ? k : w - 1 - k;
      if (!found && d[i]) begin
        found = 1'b1;
        r.pos = 7'(i);
        r.cnt = 8'(k);
        r.zero = 1'b0;
      end
    end
    r.norm = r.zero ? 64'd0 : (m ? d >> r.cnt : (d << r.cnt) & mask);
    return r;
  endfunction
  task automatic test_reset;
    rst_n = 0; in_valid = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    checks++;
    if ({ov32, pos32, cnt32, z32, norm32, tag32} !== '0 || rdy32 !== 1'b1) begin
      failures++;
      $display("FAIL reset: ov=%b pos=%0d cnt=%0d zero=%b norm=%h tag=%0d rdy=%b, want all 0 and rdy=1",
               ov32, pos32, cnt32, z32, norm32, tag32, rdy32);
    end
  endtask
  task automatic test_directed;
    logic [31:0] dv [5];
    logic        mv [5];
    logic [4:0]  ep [5];
    logic [5:0]  ec [5];
    logic        ez [5];
    logic [31:0] en [5];
    dv = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0A00, 32'h0, 32'h0};
    mv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ep = '{5'd16, 5'd31, 5'd9, 5'd0, 5'd0};
    ec = '{6'd15, 6'd0, 6'd9, 6'd32, 6'd32};
    ez = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    en = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0, 32'h0};
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; din = {32'h0, dv[k]}; in_mode = mv[k]; in_tag = 4'(k + 3);
      @(posedge clk); #1;
      in_valid = 0;
      checks++;
      if (ov32 !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_early: out_valid=%b one cycle after accept, want 0", k, ov32);
      end
      @(posedge clk); #1;
      checks++;
      if ({ov32, pos32, cnt32, z32, norm32, tag32} !== {1'b1, ep[k], ec[k], ez[k], en[k], 4'(k + 3)}) begin
        failures++;
        $display("FAIL directed%0d: ov=%b pos=%0d cnt=%0d zero=%b norm=%h tag=%0d, want 1 %0d %0d %b %h %0d",
                 k, ov32, pos32, cnt32, z32, norm32, tag32, ep[k], ec[k], ez[k], en[k], k + 3);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back;
    int sent = 0, got = 0, stall = 0, last = -1;
    logic started = 0;
    logic [47:0] snap = '0;
    res_t r;
    out_ready = 1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      in_valid = (sent < 5);
      din = {32'h0, 32'h1 << (sent * 6 + 1)};
      in_mode = sent[0];
      in_tag = 4'(sent);
      if (!started && ov32 && tag32 == 4'd0) begin
        started = 1; stall = 4;
        snap = {pos32, cnt32, z32, norm32, tag32};
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if ({pos32, cnt32, z32, norm32, tag32} !== snap || ov32 !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold: outputs %h ov=%b changed while stalled, want %h ov=1",
                   {pos32, cnt32, z32, norm32, tag32}, ov32, snap);
        end
        checks++;
        if (rdy32 !== 1'b0 || sent != 2) begin
          failures++;
          $display("FAIL bp_full: in_ready=%b pending_tag=%0d while stalled, want 0 and 2", rdy32, sent);
        end
      end
      if (in_valid && rdy32) sent++;
      if (ov32 && out_ready) begin
        r = model(32, {32'h0, 32'h1 << (got * 6 + 1)}, got[0]);
        checks++;
        if ({pos32, cnt32, z32, norm32, tag32} !== {r.pos[4:0], r.cnt[5:0], r.zero, r.norm[31:0], 4'(got)}
            || (got > 0 && cyc != last + 1)) begin
          failures++;
          $display("FAIL bp_out%0d: pos=%0d cnt=%0d zero=%b norm=%h tag=%0d cyc=%0d last=%0d, want %0d %0d %b %h %0d consecutive",
                   got, pos32, cnt32, z32, norm32, tag32, cyc, last, r.pos, r.cnt, r.zero, r.norm[31:0], got);
        end
        last = cyc;
        got++;
      end
      if (stall > 0) stall--;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    checks++;
    if (got != 5 || !started) begin
      failures++;
      $display("FAIL bp_count: emitted=%0d stalled=%b, want 5 and 1", got, started);
    end
  endtask
  task automatic test_reset_mid;
    out_ready = 1;
    in_valid = 1; din = 64'h0000_00F0; in_mode = 0; in_tag = 4'd5;
    @(posedge clk); #1;
    din = 64'h0000_0300; in_mode = 1; in_tag = 4'd6;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if ({ov32, pos32, cnt32, z32, norm32, tag32} !== '0 || rdy32 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: ov=%b pos=%0d cnt=%0d zero=%b norm=%h tag=%0d rdy=%b, want all 0 and rdy=1",
               ov32, pos32, cnt32, z32, norm32, tag32, rdy32);
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ov32 !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_ghost: out_valid=%b tag=%0d after reset, want 0", ov32, tag32);
      end
    end
    in_valid = 1; din = 64'h0000_0100; in_mode = 0; in_tag = 4'd9;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if ({ov32, pos32, cnt32, z32, norm32, tag32} !== {1'b1, 5'd8, 6'd23, 1'b0, 32'h8000_0000, 4'd9}) begin
      failures++;
      $display("FAIL mid_reset_new: ov=%b pos=%0d cnt=%0d zero=%b norm=%h tag=%0d, want 1 8 23 0 80000000 9",
               ov32, pos32, cnt32, z32, norm32, tag32);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_random;
    txn_t q[$];
    txn_t e;
    res_t r;
    int acc = 0, emit = 0, cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: din = '0;
        1: din = 64'd1 << $urandom_range(0, 63);
        2: din = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: din = {$urandom, $urandom};
      endcase
      in_mode = 1'($urandom_range(0, 1));
      in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ({rdy8, rdy16, rdy64} !== {3{rdy32}} || {ov8, ov16, ov64} !== {3{ov32}}) begin
        failures++;
        $display("FAIL rnd_hs: rdy=%b%b%b%b ov=%b%b%b%b, want all equal", rdy8, rdy16, rdy32, rdy64, ov8, ov16, ov32, ov64);
      end
      if (ov32 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_dup: output tag=%0d with empty scoreboard, want none", tag32);
        end else begin
          e = q.pop_front();
          r = model(8, e.d, e.m);
          if ({pos8, cnt8, z8, norm8, tag8} !== {r.pos[2:0], r.cnt[3:0], r.zero, r.norm[7:0], e.t}) begin
            failures++;
            $display("FAIL rnd_w8 #%0d: pos=%0d cnt=%0d z=%b norm=%h tag=%0d, want %0d %0d %b %h %0d",
                     emit, pos8, cnt8, z8, norm8, tag8, r.pos, r.cnt, r.zero, r.norm[7:0], e.t);
          end
          checks++;
          r = model(16, e.d, e.m);
          if ({pos16, cnt16, z16, norm16, tag16} !== {r.pos[3:0], r.cnt[4:0], r.zero, r.norm[15:0], e.t}) begin
            failures++;
            $display("FAIL rnd_w16 #%0d: pos=%0d cnt=%0d z=%b norm=%h tag=%0d, want %0d %0d %b %h %0d",
                     emit, pos16, cnt16, z16, norm16, tag16, r.pos, r.cnt, r.zero, r.norm[15:0], e.t);
          end
          checks++;
          r = model(32, e.d, e.m);
          if ({pos32, cnt32, z32, norm32, tag32} !== {r.pos[4:0], r.cnt[5:0], r.zero, r.norm[31:0], e.t}) begin
            failures++;
            $display("FAIL rnd_w32 #%0d: pos=%0d cnt=%0d z=%b norm=%h tag=%0d, want %0d %0d %b %h %0d",
                     emit, pos32, cnt32, z32, norm32, tag32, r.pos, r.cnt, r.zero, r.norm[31:0], e.t);
          end
          checks++;
          r = model(64, e.d, e.m);
          if ({pos64, cnt64, z64, norm64, tag64} !== {r.pos[5:0], r.cnt[6:0], r.zero, r.norm, e.t}) begin
            failures++;
            $display("FAIL rnd_w64 #%0d: pos=%0d cnt=%0d z=%b norm=%h tag=%0d, want %0d %0d %b %h %0d",
                     emit, pos64, cnt64, z64, norm64, tag64, r.pos, r.cnt, r.zero, r.norm, e.t);
          end
        end
        emit++;
      end
      if (in_valid && rdy32) begin
        q.push_back('{d: din, m: in_mode, t: in_tag});
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      #1;
      if (ov32) begin
        e = q.pop_front();
        r = model(32, e.d, e.m);
        checks++;
        if ({pos32, cnt32, z32, norm32, tag32} !== {r.pos[4:0], r.cnt[5:0], r.zero, r.norm[31:0], e.t}) begin
          failures++;
          $display("FAIL rnd_drain #%0d: pos=%0d cnt=%0d z=%b norm=%h tag=%0d, want %0d %0d %b %h %0d",
                   emit, pos32, cnt32, z32, norm32, tag32, r.pos, r.cnt, r.zero, r.norm[31:0], e.t);
        end
        emit++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (acc != 10000 || emit != acc || q.size() != 0) begin
      failures++;
      $display("FAIL rnd_count: accepted=%0d emitted=%0d left=%0d, want 10000 10000 0", acc, emit, q.size());
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
